data_memory_arbiter: RTL
========================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, log2 of the memory word count (16 words).
REQ-004 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-006 SHALL have ports REQ0/REQ1  input  1  access request from requester 0/1.
REQ-007 SHALL have ports WE0/WE1  input  1  1 = write, 0 = read, qualified by REQx.
REQ-008 SHALL have ports AD0/AD1  input  ADDR_W  word address, qualified by REQx.
REQ-009 SHALL have ports WD0/WD1  input  DATA_W  write data, qualified by REQx and WEx.
REQ-010 SHALL have ports GNT0/GNT1  output  1  one-cycle grant pulse; the request has been accepted.
REQ-011 SHALL have ports ERR0/ERR1  output  1  one-cycle pulse with GNTx when the address is out of range.
REQ-012 SHALL have ports RV0/RV1  output  1  one-cycle read-data-valid pulse.
REQ-013 SHALL have ports RD0/RD1  output  DATA_W  read data, valid while RVx=1.
REQ-014 SHALL have port W_DM  output  1  memory write strobe.
REQ-015 SHALL have port AD  output  ADDR_W  memory address.
REQ-016 SHALL have port WP  output  DATA_W  memory write data.
REQ-017 SHALL have port PR  input  DATA_W  memory read data, registered by the memory one cycle after the address is presented.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-019 In IDLE with any REQx=1, SHALL latch the winner's WE/AD/WD, record the winner, and go to ACCESS.
REQ-020 Arbitration SHALL be round-robin: when both request, the requester not served last wins; a single requester always wins.
REQ-021 In ACCESS, SHALL assert GNTx of the winner for exactly one cycle and drive AD and WP from the latched values.
REQ-022 In ACCESS, W_DM SHALL be 1 only for a write with latched address < 2**DEPTH_LOG2; otherwise W_DM SHALL be 0.
REQ-023 A write, or any out-of-range access, SHALL go ACCESS -> IDLE; an in-range read SHALL go ACCESS -> RESP.
REQ-024 In RESP, SHALL hold AD unchanged, copy PR to RDx, and pulse RVx of the winner for one cycle, then go to IDLE.
REQ-025 An out-of-range access SHALL pulse ERRx together with GNTx, SHALL NOT write, and SHALL produce no RVx.
REQ-026 Latency SHALL be fixed: REQ sampled in IDLE at cycle N gives GNT at N+1 and, for a read, RV at N+2.
REQ-027 Requests SHALL be sampled only in IDLE; a requester SHALL hold REQx, WEx, ADx and WDx stable until its GNTx.
REQ-028 Back-to-back throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-029 GNT0 and GNT1 SHALL never be 1 in the same cycle; the same SHALL hold for RV0/RV1 and for ERR0/ERR1.
REQ-030 RDx SHALL hold its last value when RVx=0; the losing requester's RD SHALL be unchanged.
REQ-031 A requester whose REQx is still 1 after its grant SHALL be treated as a new request.

Reset
REQ-032 With RST=1 at a clock edge, SHALL enter IDLE and clear GNTx, ERRx, RVx, W_DM, AD, WP and RDx to 0.
REQ-033 Reset SHALL set the round-robin pointer so requester 0 wins the first tie.
REQ-034 Reset during ACCESS or RESP SHALL abort the transaction: no RVx and no further W_DM for it.

Verification
REQ-035 Single write: REQ0=1, WE0=1, AD0=3, WD0=0xA5A5A5A5 -> GNT0 and W_DM=1, AD=3, WP=0xA5A5A5A5 at N+1; no RV0.
REQ-036 Read-back: REQ1=1, WE1=0, AD1=3 after REQ-035 -> GNT1 at N+1, RV1=1 and RD1=0xA5A5A5A5 at N+2.
REQ-037 Tie after reset: REQ0 and REQ1 both held as reads -> grant order 0, 1, 0, 1; each GNT is followed by the matching RV.
REQ-038 Out of range: REQ0 write with AD0=16 -> GNT0 and ERR0 at N+1, W_DM=0, no RV0; the FSM is in IDLE at N+2.
REQ-039 Reset mid-read: assert RST in the ACCESS cycle of a read -> no RVx, all outputs 0, and the next REQ1 is granted normally.
REQ-040 Continuous checks for the whole run: GNT, RV and ERR pairs are never both 1, and W_DM is 1 only in an in-range write ACCESS cycle.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Fixed latency: grant one cycle after the request is sampled, read data one cycle later.
module data_memory_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] AD0,
    input  logic [ADDR_W-1:0] AD1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              ERR0,
    output logic              ERR1,
    output logic              RV0,
    output logic              RV1,
    output logic [DATA_W-1:0] RD0,
    output logic [DATA_W-1:0] RD1,
    output logic              W_DM,
    output logic [ADDR_W-1:0] AD,
    output logic [DATA_W-1:0] WP,
    input  logic [DATA_W-1:0] PR
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              win;
    logic              last_win;
    logic              pick;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_ad;
    logic [DATA_W-1:0] lat_wd;
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;
    logic              in_range;

    // A tie goes to whoever was not served last; a lone requester always wins.
    assign pick     = (REQ0 && REQ1) ? ~last_win : REQ1;
    assign in_range = (lat_ad >> DEPTH_LOG2) == '0;

    assign AD = lat_ad;
    assign WP = lat_wd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_win <= 1'b1;
            win      <= 1'b0;
            lat_we   <= 1'b0;
            lat_ad   <= '0;
            lat_wd   <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (REQ0 || REQ1)) begin
                win      <= pick;
                last_win <= pick;
                lat_we   <= pick ? WE1 : WE0;
                lat_ad   <= pick ? AD1 : AD0;
                lat_wd   <= pick ? WD1 : WD0;
            end
            if (state == RESP) begin
                if (win) rd1_q <= PR;
                else     rd0_q <= PR;
            end
        end
    end

    // RDx shows PR directly during its RV cycle and the captured copy afterwards.
    always_comb begin
        state_nxt = state;
        GNT0      = 1'b0;
        GNT1      = 1'b0;
        ERR0      = 1'b0;
        ERR1      = 1'b0;
        RV0       = 1'b0;
        RV1       = 1'b0;
        W_DM      = 1'b0;
        RD0       = rd0_q;
        RD1       = rd1_q;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) state_nxt = ACCESS;
            end
            ACCESS: begin
                GNT0      = ~win;
                GNT1      = win;
                ERR0      = ~win && !in_range;
                ERR1      = win && !in_range;
                W_DM      = lat_we && in_range;
                state_nxt = (lat_we || !in_range) ? IDLE : RESP;
            end
            RESP: begin
                RV0       = ~win;
                RV1       = win;
                if (win) RD1 = PR;
                else     RD0 = PR;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
